// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
// Module   : ula_seq
// Brief    : Registered WIDTH-bit ALU with valid/ready handshakes, status
//            flags, accumulator and optional shift-add multiplier
//            (multiplier built only when ULA_MUL_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             err
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;
    localparam logic [2:0] c_OP_ACC = 3'b111;
    localparam int         c_MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             w_accept;

    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_acc_new;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c;
    logic             w_v;
    logic             w_err;

    assign w_accept = in_valid && in_ready;

    // Single-cycle result; acc_clr zeroes the accumulator ahead of the op.
    always_comb begin
        w_acc_base = acc_clr ? '0 : r_acc;
        w_acc_new  = w_acc_base;
        w_res      = '0;
        w_sum      = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        w_err      = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[c_MSB] == b[c_MSB]) && (w_res[c_MSB] != a[c_MSB]);
            end
            c_OP_SUB: begin
                w_sum = {1'b0, a} - {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[c_MSB] != b[c_MSB]) && (w_res[c_MSB] != a[c_MSB]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_MUL: begin
`ifndef ULA_MUL_EN
                w_err = 1'b1;
`endif
            end
            c_OP_ACC: begin
                w_sum     = {1'b0, w_acc_base} + {1'b0, a};
                w_res     = w_sum[WIDTH-1:0];
                w_c       = w_sum[WIDTH];
                w_v       = (w_acc_base[c_MSB] == a[c_MSB]) && (w_res[c_MSB] != a[c_MSB]);
                w_acc_new = w_res;
            end
        endcase
    end

`ifdef ULA_MUL_EN
    localparam int                c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mhi;
    logic [WIDTH-1:0] r_mlo;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mhi_nx;
    logic [WIDTH-1:0] w_mlo_nx;

    // {hi,lo} starts as {0,b}; each step adds mcand on lo[0] and shifts right.
    assign w_madd   = r_mlo[0] ? ({1'b0, r_mhi} + {1'b0, r_mcand}) : {1'b0, r_mhi};
    assign w_mhi_nx = w_madd[WIDTH:1];
    assign w_mlo_nx = {w_madd[0], r_mlo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            y_hi      <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            err       <= 1'b0;
`ifdef ULA_MUL_EN
            r_mcand   <= '0;
            r_mhi     <= '0;
            r_mlo     <= '0;
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= w_acc_new;
                        in_ready <= 1'b0;
`ifdef ULA_MUL_EN
                        if (op == c_OP_MUL) begin
                            r_mcand <= a;
                            r_mhi   <= '0;
                            r_mlo   <= b;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else
`endif
                        begin
                            y         <= w_res;
                            y_hi      <= '0;
                            carry     <= w_c;
                            overflow  <= w_v;
                            zero      <= (w_res == '0);
                            negative  <= w_res[c_MSB];
                            err       <= w_err;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
`ifdef ULA_MUL_EN
                BUSY: begin
                    r_mhi <= w_mhi_nx;
                    r_mlo <= w_mlo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        y         <= w_mlo_nx;
                        y_hi      <= w_mhi_nx;
                        carry     <= |w_mhi_nx;
                        overflow  <= 1'b0;
                        zero      <= (w_mlo_nx == '0);
                        negative  <= w_mlo_nx[c_MSB];
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_seq
// Brief    : Directed self-checking bench for ula_seq (WIDTH=8); follows the
//            ULA_MUL_EN build selection of the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         err;

    int checks = 0;
    int errors = 0;

    ula_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Flags packed as {carry, overflow, zero, negative, err}
    function automatic logic [4:0] flags();
        return {carry, overflow, zero, negative, err};
    endfunction

    // Presents one command and returns 1ns after the accept edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2:0] iop, input logic iclr);
        @(negedge clk);
        a = ia; b = ib; op = iop; acc_clr = iclr; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    // Edges after the accept edge until out_valid; -1 if it never arrives.
    task automatic wait_out(output int lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = out_valid ? n : -1;
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        acc_clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, y, y_hi, flags()} !== {1'b1, 1'b0, 8'h00, 8'h00, 5'b00000}) begin
            errors++;
            $display("FAIL reset: got %b expected %b",
                     {in_ready, out_valid, y, y_hi, flags()}, {1'b1, 1'b0, 8'h00, 8'h00, 5'b00000});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        issue(8'hFF, 8'h01, 3'b000, 1'b0);
        wait_out(lat);
        checks++;
        if (lat != 0) begin errors++; $display("FAIL add_latency: got %0d expected 0", lat); end
        checks++;
        if ({y, y_hi, flags()} !== {8'h00, 8'h00, 5'b10100}) begin
            errors++; $display("FAIL add_ff_01: got y=%h yhi=%h f=%b expected y=00 yhi=00 f=10100", y, y_hi, flags());
        end
        pop();
        issue(8'h7F, 8'h01, 3'b000, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h80, 5'b01010}) begin
            errors++; $display("FAIL add_7f_01: got y=%h f=%b expected y=80 f=01010", y, flags());
        end
        pop();
    endtask

    task automatic test_sub_logic();
        int lat;
        issue(8'h80, 8'h01, 3'b001, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h7F, 5'b01000}) begin
            errors++; $display("FAIL sub_80_01: got y=%h f=%b expected y=7f f=01000", y, flags());
        end
        pop();
        issue(8'h01, 8'h02, 3'b001, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'hFF, 5'b10010}) begin
            errors++; $display("FAIL sub_01_02: got y=%h f=%b expected y=ff f=10010", y, flags());
        end
        pop();
        issue(8'hFF, 8'h01, 3'b101, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h01, 5'b00000}) begin
            errors++; $display("FAIL slt_ff_01: got y=%h f=%b expected y=01 f=00000", y, flags());
        end
        pop();
        issue(8'hF0, 8'h3C, 3'b010, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h30, 5'b00000}) begin
            errors++; $display("FAIL and: got y=%h f=%b expected y=30 f=00000", y, flags());
        end
        pop();
        issue(8'hF0, 8'h3C, 3'b011, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'hFC, 5'b00010}) begin
            errors++; $display("FAIL or: got y=%h f=%b expected y=fc f=00010", y, flags());
        end
        pop();
        issue(8'hA5, 8'hA5, 3'b100, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h00, 5'b00100}) begin
            errors++; $display("FAIL xor: got y=%h f=%b expected y=00 f=00100", y, flags());
        end
        pop();
    endtask

    task automatic test_mul();
        int lat;
`ifdef ULA_MUL_EN
        int  n = 0;
        logic busy_bad = 1'b0;
        issue(8'h0F, 8'h11, 3'b110, 1'b0);
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!out_valid || n != 8 || busy_bad) begin
            errors++; $display("FAIL mul_latency: got edges=%0d in_ready_seen=%b expected 8 and 0", n, busy_bad);
        end
        checks++;
        if ({y, y_hi, flags()} !== {8'hFF, 8'h00, 5'b00010}) begin
            errors++; $display("FAIL mul_0f_11: got y=%h yhi=%h f=%b expected y=ff yhi=00 f=00010", y, y_hi, flags());
        end
        pop();
        issue(8'hFF, 8'hFF, 3'b110, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, y_hi, flags()} !== {8'h01, 8'hFE, 5'b10000}) begin
            errors++; $display("FAIL mul_ff_ff: got y=%h yhi=%h f=%b expected y=01 yhi=fe f=10000", y, y_hi, flags());
        end
        pop();
`else
        issue(8'h03, 8'h04, 3'b110, 1'b0);
        wait_out(lat);
        checks++;
        if (lat != 0) begin errors++; $display("FAIL mul_off_latency: got %0d expected 0", lat); end
        checks++;
        if ({y, y_hi, flags()} !== {8'h00, 8'h00, 5'b00101}) begin
            errors++; $display("FAIL mul_off: got y=%h yhi=%h f=%b expected y=00 yhi=00 f=00101", y, y_hi, flags());
        end
        pop();
        issue(8'h03, 8'h04, 3'b000, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h07, 5'b00000}) begin
            errors++; $display("FAIL add_after_mul_off: got y=%h f=%b expected y=07 f=00000", y, flags());
        end
        pop();
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        issue(8'h12, 8'h34, 3'b000, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'hFF; b = 8'hFF; op = 3'b001;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, y, flags()} !== {1'b1, 1'b0, 8'h46, 5'b00000}) begin
                errors++; $display("FAIL hold_%0d: got v=%b r=%b y=%h f=%b expected v=1 r=0 y=46 f=00000",
                                   i, out_valid, in_ready, y, flags());
            end
        end
        pop();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_acc();
        int lat;
        issue(8'h05, 8'hAA, 3'b111, 1'b1);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h05, 5'b00000}) begin
            errors++; $display("FAIL acc_clr_5: got y=%h f=%b expected y=05 f=00000", y, flags());
        end
        pop();
        issue(8'h03, 8'h00, 3'b111, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h08, 5'b00000}) begin
            errors++; $display("FAIL acc_3: got y=%h f=%b expected y=08 f=00000", y, flags());
        end
        pop();
        issue(8'hF8, 8'h00, 3'b111, 1'b0);
        wait_out(lat);
        checks++;
        if ({y, flags()} !== {8'h00, 5'b10100}) begin
            errors++; $display("FAIL acc_f8: got y=%h f=%b expected y=00 f=10100", y, flags());
        end
        pop();
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(8'h09, 8'h00, 3'b111, 1'b0);
        wait_out(lat);
        pop();
`ifdef ULA_MUL_EN
        issue(8'h0F, 8'h11, 3'b110, 1'b0);
        repeat (3) @(posedge clk);
        #1;
`else
        issue(8'h0F, 8'h11, 3'b000, 1'b0);
`endif
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, y} !== {1'b0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL reset_mid: got v=%b r=%b y=%h expected v=0 r=1 y=00", out_valid, in_ready, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h01, 8'h00, 3'b111, 1'b0);
        wait_out(lat);
        checks++;
        if (y !== 8'h01) begin
            errors++; $display("FAIL acc_after_reset: got y=%h expected y=01", y);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'h02, 8'h03, 3'b000, 1'b1);
        wait_out(lat);
        checks++;
        if (y !== 8'h05) begin errors++; $display("FAIL add_with_clr: got y=%h expected y=05", y); end
        pop();
        issue(8'h04, 8'h00, 3'b111, 1'b0);
        wait_out(lat);
        checks++;
        if ({lat, y} !== {32'sd0, 8'h04}) begin
            errors++; $display("FAIL acc_after_clr: got lat=%0d y=%h expected lat=0 y=04", lat, y);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_logic();
        test_mul();
        test_backpressure();
        test_acc();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
